instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 187 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Turns a bundle of MIPS instruction fields into one 32-bit instruction word
//   and hands it downstream, with its byte address, over a valid/ready
//   handshake. Addresses step by 4 from an internal next-address register that
//   can be reloaded at any time. Illegal kinds are consumed silently and raise
//   a sticky error flag.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   reset        synchronous active-low reset
//   in_valid     field bundle present
//   in_ready     encoder can take a bundle this cycle
//   in_kind      0=R 1=ADDI 2=ORI 3=LUI 4=BEQ 5=BNE 6=SW 7=LW 8=J 9=JAL
//   rs/rt/rd/shamt/funct/imm/target   instruction fields
//   addr_load    load addr_in (low two bits dropped) as the next word address
//   addr_in      new base address
//   out_valid    out_instr/out_addr hold a word
//   out_ready    downstream takes the word
//   out_instr    encoded instruction word
//   out_addr     byte address of out_instr
//   err_illegal  sticky: an illegal kind was consumed since reset
//   word_count   words taken downstream, saturating at 0xFFFF
//
// Configuration
//   INSTR_ENCODER_JAL_EN  defined: kind 9 encodes JAL; undefined: kind 9 is
//                         illegal.
// ---------------------------------------------------------------------------
module instr_encoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    input  logic        addr_load,
    input  logic [31:0] addr_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [15:0] word_count
);

    typedef enum logic [3:0] {
        KIND_R    = 4'd0,
        KIND_ADDI = 4'd1,
        KIND_ORI  = 4'd2,
        KIND_LUI  = 4'd3,
        KIND_BEQ  = 4'd4,
        KIND_BNE  = 4'd5,
        KIND_SW   = 4'd6,
        KIND_LW   = 4'd7,
        KIND_J    = 4'd8,
        KIND_JAL  = 4'd9
    } kind_e;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_J    = 6'h02;
`ifdef INSTR_ENCODER_JAL_EN
    localparam logic [5:0] OP_JAL  = 6'h03;
`endif

    localparam logic [31:0] RESET_ADDR = 32'h0040_0000;

    logic        out_valid_q,   out_valid_d;
    logic [31:0] out_instr_q,   out_instr_d;
    logic [31:0] out_addr_q,    out_addr_d;
    logic [31:0] nxt_addr_q,    nxt_addr_d;
    logic        err_illegal_q, err_illegal_d;
    logic [15:0] word_count_q,  word_count_d;

    logic        kind_legal;
    logic [31:0] instr_enc;
    logic        accept;
    logic        legal_accept;
    logic        drain;
    logic [31:0] load_addr;
    logic [31:0] base_addr;

    // Field packing for the incoming bundle.
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave a value unassigned and infer a latch.
    always_comb begin
        kind_legal = 1'b1;
        instr_enc  = '0;
        case (kind_e'(in_kind))
            KIND_R:    instr_enc = {OP_R, rs, rt, rd, shamt, funct};
            KIND_ADDI: instr_enc = {OP_ADDI, rs, rt, imm};
            KIND_ORI:  instr_enc = {OP_ORI,  rs, rt, imm};
            KIND_LUI:  instr_enc = {OP_LUI, 5'b0_0000, rt, imm};
            KIND_BEQ:  instr_enc = {OP_BEQ,  rs, rt, imm};
            KIND_BNE:  instr_enc = {OP_BNE,  rs, rt, imm};
            KIND_SW:   instr_enc = {OP_SW,   rs, rt, imm};
            KIND_LW:   instr_enc = {OP_LW,   rs, rt, imm};
            KIND_J:    instr_enc = {OP_J, target};
`ifdef INSTR_ENCODER_JAL_EN
            KIND_JAL:  instr_enc = {OP_JAL, target};
`else
            KIND_JAL:  kind_legal = 1'b0;
`endif
            default:   kind_legal = 1'b0;
        endcase
    end

    // A new word may enter whenever the output register is empty or is being
    // emptied this cycle.
    assign in_ready     = !out_valid_q || out_ready;
    assign accept       = in_valid && in_ready;
    assign legal_accept = accept && kind_legal;
    assign drain        = out_valid_q && out_ready;

    // Masking rather than slicing keeps the word alignment explicit.
    assign load_addr = addr_in & 32'hFFFF_FFFC;
    // A load in the same cycle as a legal accept addresses that very word.
    assign base_addr = addr_load ? load_addr : nxt_addr_q;

    always_comb begin
        out_valid_d   = out_valid_q;
        out_instr_d   = out_instr_q;
        out_addr_d    = out_addr_q;
        nxt_addr_d    = nxt_addr_q;
        err_illegal_d = err_illegal_q;
        word_count_d  = word_count_q;

        if (drain) begin
            out_valid_d = 1'b0;
            if (word_count_q != 16'hFFFF) begin
                word_count_d = word_count_q + 16'd1;
            end
        end

        if (legal_accept) begin
            out_valid_d = 1'b1;
            out_instr_d = instr_enc;
            out_addr_d  = base_addr;
            nxt_addr_d  = base_addr + 32'd4;   // wraps modulo 2^32
        end else if (addr_load) begin
            nxt_addr_d  = load_addr;
        end

        if (accept && !kind_legal) begin
            err_illegal_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q   <= 1'b0;
            out_instr_q   <= '0;
            out_addr_q    <= RESET_ADDR;
            nxt_addr_q    <= RESET_ADDR;
            err_illegal_q <= 1'b0;
            word_count_q  <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_instr_q   <= out_instr_d;
            out_addr_q    <= out_addr_d;
            nxt_addr_q    <= nxt_addr_d;
            err_illegal_q <= err_illegal_d;
            word_count_q  <= word_count_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_instr_q;
    assign out_addr    = out_addr_q;
    assign err_illegal = err_illegal_q;
    assign word_count  = word_count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Self-checking bench for instr_encoder. A transaction-level model (a queue
//   of expected words plus the next-address, error and count values) is
//   advanced on every rising edge from the driven inputs only; a compare
//   process checks every DUT output against it on each falling edge. Directed
//   sequences pin the model with hand-computed literal words and addresses,
//   then a randomized phase exercises handshakes, reloads, illegal kinds and
//   resets.
// ---------------------------------------------------------------------------
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_kind;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
    logic        addr_load;
    logic [31:0] addr_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err_illegal;
    logic [15:0] word_count;

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_kind     (in_kind),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm),
        .target      (target),
        .addr_load   (addr_load),
        .addr_in     (addr_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

`ifdef INSTR_ENCODER_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } word_t;

    word_t       exp_q[$];
    logic [31:0] m_nxt   = 32'h0040_0000;
    logic        m_err   = 1'b0;
    int          m_cnt   = 0;
    bit          started = 1'b0;

    function automatic bit model_legal(input logic [3:0] k);
        return (k <= 4'd8) || (k == 4'd9 && JAL_EN);
    endfunction

    // Opcode per kind index, straight from the instruction-set table.
    function automatic logic [31:0] model_opcode(input logic [3:0] k);
        case (k)
            4'd0: return 32'h00;  4'd1: return 32'h08;  4'd2: return 32'h0D;
            4'd3: return 32'h0F;  4'd4: return 32'h04;  4'd5: return 32'h05;
            4'd6: return 32'h2B;  4'd7: return 32'h23;  4'd8: return 32'h02;
            default: return 32'h03;
        endcase
    endfunction

    function automatic logic [31:0] model_encode(
        input logic [3:0] k, input logic [4:0] f_rs, input logic [4:0] f_rt,
        input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
        input logic [15:0] f_imm, input logic [25:0] f_tgt);
        logic [31:0] w;
        w = model_opcode(k) << 26;
        if (k == 4'd0)
            w = w + (32'(f_rs) << 21) + (32'(f_rt) << 16) + (32'(f_rd) << 11)
                  + (32'(f_sh) << 6) + 32'(f_fn);
        else if (k == 4'd3)
            w = w + (32'(f_rt) << 16) + 32'(f_imm);
        else if (k >= 4'd8)
            w = w + 32'(f_tgt);
        else
            w = w + (32'(f_rs) << 21) + (32'(f_rt) << 16) + 32'(f_imm);
        return w;
    endfunction

    // Model step on each rising edge, using the inputs as they stood before it.
    always @(posedge clk) begin
        bit          m_vld;
        logic [31:0] a;
        if (!reset) begin
            exp_q.delete();
            m_nxt   = 32'h0040_0000;
            m_err   = 1'b0;
            m_cnt   = 0;
            started = 1'b1;
        end else begin
            m_vld = (exp_q.size() != 0);
            if (m_vld && out_ready) begin
                void'(exp_q.pop_front());
                if (m_cnt < 65535) m_cnt++;
            end
            if (in_valid && (!m_vld || out_ready)) begin
                if (model_legal(in_kind)) begin
                    a = addr_load ? (addr_in & 32'hFFFF_FFFC) : m_nxt;
                    exp_q.push_back('{model_encode(in_kind, rs, rt, rd, shamt, funct, imm, target), a});
                    m_nxt = a + 32'd4;
                end else begin
                    m_err = 1'b1;
                    if (addr_load) m_nxt = addr_in & 32'hFFFF_FFFC;
                end
            end else if (addr_load) begin
                m_nxt = addr_in & 32'hFFFF_FFFC;
            end
        end
    end

    // Compare on every falling edge once a reset has been seen.
    always @(negedge clk) begin
        if (started) begin
            check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_ready), 32'((exp_q.size() == 0) || out_ready));
            check("err_illegal", 32'(err_illegal), 32'(m_err));
            check("word_count", 32'(word_count), 32'(m_cnt));
            if (exp_q.size() != 0) begin
                check("out_instr", out_instr, exp_q[0].instr);
                check("out_addr", out_addr, exp_q[0].addr);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bundle(input logic [3:0] k, input logic [4:0] f_rs, input logic [4:0] f_rt,
                          input logic [4:0] f_rd, input logic [4:0] f_sh, input logic [5:0] f_fn,
                          input logic [15:0] f_imm, input logic [25:0] f_tgt);
        in_valid = 1'b1;
        in_kind  = k;  rs = f_rs;  rt = f_rt;  rd = f_rd;
        shamt    = f_sh;  funct = f_fn;  imm = f_imm;  target = f_tgt;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_kind   = '0;  rs = '0;  rt = '0;  rd = '0;  shamt = '0;
        funct     = '0;  imm = '0;  target = '0;
        addr_load = 1'b0;
        addr_in   = '0;
        out_ready = 1'b1;
        tick();
        // Reset state.
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_out_addr", out_addr, 32'h0040_0000);
        check("rst_err", 32'(err_illegal), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        reset = 1'b1;

        // R-type add $8,$9,$10.
        bundle(4'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h0, 26'h0);
        tick();
        check("r_instr", out_instr, 32'h012A_4020);
        check("r_addr", out_addr, 32'h0040_0000);
        in_valid = 1'b0;
        tick();
        check("r_count", 32'(word_count), 32'd1);

        // Back-to-back ADDI then LUI with no bubble.
        do_reset();
        bundle(4'd1, 5'd0, 5'd8, 5'd0, 5'd0, 6'h0, 16'h0005, 26'h0);
        tick();
        check("addi_instr", out_instr, 32'h2008_0005);
        check("addi_addr", out_addr, 32'h0040_0000);
        bundle(4'd3, 5'd7, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1001, 26'h0);
        tick();
        check("lui_valid", 32'(out_valid), 32'd1);
        check("lui_instr", out_instr, 32'h3C01_1001);
        check("lui_addr", out_addr, 32'h0040_0004);
        in_valid = 1'b0;
        tick();

        // J held under back-pressure, second bundle waiting.
        do_reset();
        out_ready = 1'b0;
        bundle(4'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h010_0000);
        tick();
        bundle(4'd1, 5'd2, 5'd3, 5'd0, 5'd0, 6'h0, 16'h0010, 26'h0);
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_instr", out_instr, 32'h0810_0000);
            check("stall_addr", out_addr, 32'h0040_0000);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("stall_next_instr", out_instr, 32'h2043_0010);
        check("stall_next_addr", out_addr, 32'h0040_0004);
        in_valid = 1'b0;
        tick();

        // Address wrap at the top of the address space.
        addr_load = 1'b1;
        addr_in   = 32'hFFFF_FFFE;
        tick();
        addr_load = 1'b0;
        bundle(4'd4, 5'd1, 5'd2, 5'd0, 5'd0, 6'h0, 16'hFFFF, 26'h0);
        tick();
        check("wrap_instr", out_instr, 32'h1022_FFFF);
        check("wrap_addr0", out_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_addr1", out_addr, 32'h0000_0000);
        in_valid = 1'b0;
        tick();

        // Illegal kind: consumed, no word, address not advanced.
        do_reset();
        bundle(4'd15, 5'd1, 5'd1, 5'd1, 5'd1, 6'h1, 16'h1, 26'h1);
        tick();
        check("ill_err", 32'(err_illegal), 32'd1);
        check("ill_valid", 32'(out_valid), 32'd0);
        bundle(4'd2, 5'd4, 5'd5, 5'd0, 5'd0, 6'h0, 16'hABCD, 26'h0);
        tick();
        check("ill_next_addr", out_addr, 32'h0040_0000);
        in_valid = 1'b0;
        tick();

        // Kind 9 depends on configuration.
        do_reset();
        bundle(4'd9, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0123);
        tick();
        if (JAL_EN) begin
            check("jal_instr", out_instr, 32'h0C00_0123);
            check("jal_err", 32'(err_illegal), 32'd0);
        end else begin
            check("jal_valid", 32'(out_valid), 32'd0);
            check("jal_err", 32'(err_illegal), 32'd1);
        end
        in_valid = 1'b0;
        tick();

        // Reset mid-transfer overrides a pending word, a load and an accept.
        do_reset();
        bundle(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0001, 26'h0);
        tick();
        bundle(4'd14, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);
        tick();
        out_ready = 1'b0;
        bundle(4'd1, 5'd1, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0002, 26'h0);
        tick();
        tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        reset     = 1'b0;
        addr_load = 1'b1;
        addr_in   = 32'h1234_5678;
        tick();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_addr", out_addr, 32'h0040_0000);
        check("mid_rst_count", 32'(word_count), 32'd0);
        check("mid_rst_err", 32'(err_illegal), 32'd0);
        reset     = 1'b1;
        addr_load = 1'b0;
        in_valid  = 1'b0;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        bundle(4'd7, 5'd3, 5'd4, 5'd0, 5'd0, 6'h0, 16'h0008, 26'h0);
        tick();
        check("post_rst_addr", out_addr, 32'h0040_0000);
        in_valid = 1'b0;
        tick();

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 199) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_kind   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15))
                                                    : 4'($urandom_range(0, 8));
            rs        = 5'($urandom);
            rt        = 5'($urandom);
            rd        = 5'($urandom);
            shamt     = 5'($urandom);
            funct     = 6'($urandom);
            imm       = 16'($urandom);
            target    = 26'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            addr_in   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : $urandom;
            addr_load = ($urandom_range(0, 19) == 0);
            // Keep loads away from illegal bundles that might be consumed.
            if (in_valid && !model_legal(in_kind)) addr_load = 1'b0;
            tick();
        end

        reset     = 1'b1;
        in_valid  = 1'b0;
        addr_load = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
